// File: rtl/axi4_ram_slave.sv
// -----------------------------------------------------------------------------
// axi4_ram_slave
//   AXI4 memory-mapped slave RAM of 2**ADDR_WIDTH bytes organised as
//   DATA_WIDTH-wide words. Independent write (AW/W/B) and read (AR/R) state
//   machines share one RAM array. Intended as scratch memory behind an AXI
//   master or interconnect.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   s_axi_aw*         write address channel (lock/cache/prot accepted, ignored)
//   s_axi_w*          write data channel (wlast ignored, awlen terminates)
//   s_axi_b*          write response channel (always OKAY)
//   s_axi_ar*         read address channel (lock/cache/prot accepted, ignored)
//   s_axi_r*          read data channel (always OKAY)
//
// Burst handling: FIXED keeps the address, INCR and WRAP both advance by
// 1<<size per beat (WRAP is not wrapped). Addresses wrap modulo 2**ADDR_WIDTH.
// Lane selection uses the byte strobes only; low address bits pick no lane.
//
// Optional feature (macro AXI_RAM_READ_PIPE_EN): adds an output register on
// the R channel; first rvalid two cycles after the AR handshake, one beat per
// clock still sustained.
// -----------------------------------------------------------------------------
module axi4_ram_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int         ADDR_LSB    = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
    localparam int         WORD_AW     = ADDR_WIDTH - ADDR_LSB;
    localparam int         DEPTH       = 2 ** WORD_AW;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
`ifdef AXI_RAM_READ_PIPE_EN
    localparam bit         READ_PIPE   = 1'b1;
`else
    localparam bit         READ_PIPE   = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE = 2'b00, W_DATA = 2'b01, W_RESP = 2'b10} wr_state_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

    // Address of the following beat; FIXED holds, INCR/WRAP step by 1<<size.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] result;
        if (burst == BURST_FIXED) begin
            result = addr;
        end else begin
            result = addr + (ADDR_WIDTH'(1'b1) << size);
        end
        return result;
    endfunction

    function automatic logic [WORD_AW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1:ADDR_LSB];
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // ---------------- write path ----------------
    wr_state_t             wr_state_r, wr_state_next_s;
    logic                  awready_r, awready_next_s;
    logic                  wready_r, wready_next_s;
    logic                  bvalid_r, bvalid_next_s;
    logic [ID_WIDTH-1:0]   wr_id_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [7:0]            wr_len_r, wr_cnt_r;
    logic [2:0]            wr_size_r;
    logic [1:0]            wr_burst_r;
    logic                  aw_hs_s, w_hs_s;

    assign aw_hs_s = s_axi_awvalid && awready_r;
    assign w_hs_s  = s_axi_wvalid && wready_r;

    // Write FSM next state and next registered handshake outputs.
    always_comb begin
        wr_state_next_s = wr_state_r;
        awready_next_s  = awready_r;
        wready_next_s   = wready_r;
        bvalid_next_s   = bvalid_r;
        case (wr_state_r)
            W_IDLE: begin
                if (aw_hs_s) begin
                    wr_state_next_s = W_DATA;
                    awready_next_s  = 1'b0;
                    wready_next_s   = 1'b1;
                end else begin
                    awready_next_s  = 1'b1;
                end
            end
            W_DATA: begin
                // Beat count, not wlast, closes the burst.
                if (w_hs_s && (wr_cnt_r == wr_len_r)) begin
                    wr_state_next_s = W_RESP;
                    wready_next_s   = 1'b0;
                    bvalid_next_s   = 1'b1;
                end else begin
                    wready_next_s   = 1'b1;
                end
            end
            W_RESP: begin
                if (bvalid_r && s_axi_bready) begin
                    wr_state_next_s = W_IDLE;
                    bvalid_next_s   = 1'b0;
                    awready_next_s  = 1'b1;
                end else begin
                    bvalid_next_s   = 1'b1;
                end
            end
            default: begin
                wr_state_next_s = W_IDLE;
                awready_next_s  = 1'b0;
                wready_next_s   = 1'b0;
                bvalid_next_s   = 1'b0;
            end
        endcase
    end

    // Write FSM state and handshake output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_r <= W_IDLE;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
        end else begin
            wr_state_r <= wr_state_next_s;
            awready_r  <= awready_next_s;
            wready_r   <= wready_next_s;
            bvalid_r   <= bvalid_next_s;
        end
    end

    // Write burst context: latched on AW, stepped on each W beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_id_r    <= '0;
            wr_addr_r  <= '0;
            wr_len_r   <= 8'd0;
            wr_cnt_r   <= 8'd0;
            wr_size_r  <= 3'd0;
            wr_burst_r <= 2'b00;
        end else if (aw_hs_s) begin
            wr_id_r    <= s_axi_awid;
            wr_addr_r  <= s_axi_awaddr;
            wr_len_r   <= s_axi_awlen;
            wr_cnt_r   <= 8'd0;
            wr_size_r  <= s_axi_awsize;
            wr_burst_r <= s_axi_awburst;
        end else if (w_hs_s) begin
            wr_addr_r  <= next_addr(wr_addr_r, wr_size_r, wr_burst_r);
            wr_cnt_r   <= wr_cnt_r + 8'd1;
        end
    end

    // ---------------- read path ----------------
    rd_state_t             rd_state_r, rd_state_next_s;
    logic                  arready_r, arready_next_s;
    logic                  core_valid_r, core_valid_next_s;
    logic                  core_last_r, core_last_next_s;
    logic [DATA_WIDTH-1:0] core_data_r;
    logic [ID_WIDTH-1:0]   rd_id_r;
    logic [ADDR_WIDTH-1:0] rd_addr_r, rd_fetch_addr_s;
    logic [7:0]            rd_len_r, rd_cnt_r;
    logic [2:0]            rd_size_r;
    logic [1:0]            rd_burst_r;
    logic                  ar_hs_s, core_hs_s, core_ready_s, rd_load_s, rd_drain_busy_s;

    assign ar_hs_s   = s_axi_arvalid && arready_r;
    assign core_hs_s = core_valid_r && core_ready_s;

    // Read FSM next state; rd_load_s fetches the next beat into core_data_r.
    always_comb begin
        rd_state_next_s   = rd_state_r;
        arready_next_s    = arready_r;
        core_valid_next_s = core_valid_r;
        core_last_next_s  = core_last_r;
        rd_load_s         = 1'b0;
        rd_fetch_addr_s   = rd_addr_r;
        case (rd_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_next_s   = R_DATA;
                    arready_next_s    = 1'b0;
                    core_valid_next_s = 1'b1;
                    core_last_next_s  = (s_axi_arlen == 8'd0);
                    rd_load_s         = 1'b1;
                    rd_fetch_addr_s   = s_axi_araddr;
                end else begin
                    // Hold off a new AR while the output stage still owns the final beat.
                    arready_next_s    = !rd_drain_busy_s;
                end
            end
            R_DATA: begin
                if (core_hs_s && core_last_r) begin
                    rd_state_next_s   = R_IDLE;
                    arready_next_s    = !READ_PIPE;
                    core_valid_next_s = 1'b0;
                    core_last_next_s  = 1'b0;
                end else if (core_hs_s) begin
                    rd_load_s         = 1'b1;
                    rd_fetch_addr_s   = next_addr(rd_addr_r, rd_size_r, rd_burst_r);
                    core_last_next_s  = ((rd_cnt_r + 8'd1) == rd_len_r);
                end else begin
                    core_valid_next_s = core_valid_r;
                end
            end
            default: begin
                rd_state_next_s   = R_IDLE;
                arready_next_s    = 1'b0;
                core_valid_next_s = 1'b0;
                core_last_next_s  = 1'b0;
            end
        endcase
    end

    // Read FSM state and handshake output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_r   <= R_IDLE;
            arready_r    <= 1'b0;
            core_valid_r <= 1'b0;
            core_last_r  <= 1'b0;
        end else begin
            rd_state_r   <= rd_state_next_s;
            arready_r    <= arready_next_s;
            core_valid_r <= core_valid_next_s;
            core_last_r  <= core_last_next_s;
        end
    end

    // Read burst context: latched on AR, stepped whenever a beat is fetched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_id_r    <= '0;
            rd_addr_r  <= '0;
            rd_len_r   <= 8'd0;
            rd_cnt_r   <= 8'd0;
            rd_size_r  <= 3'd0;
            rd_burst_r <= 2'b00;
        end else if (ar_hs_s) begin
            rd_id_r    <= s_axi_arid;
            rd_addr_r  <= s_axi_araddr;
            rd_len_r   <= s_axi_arlen;
            rd_cnt_r   <= 8'd0;
            rd_size_r  <= s_axi_arsize;
            rd_burst_r <= s_axi_arburst;
        end else if (rd_load_s) begin
            rd_addr_r  <= rd_fetch_addr_s;
            rd_cnt_r   <= rd_cnt_r + 8'd1;
        end
    end

    // RAM ports; the read samples pre-write contents so a same-cycle hit returns old data.
    always_ff @(posedge clk) begin
        if (w_hs_s) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi_wstrb[i]) begin
                    mem_r[word_idx(wr_addr_r)][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
                end
            end
        end
        if (rd_load_s) begin
            core_data_r <= mem_r[word_idx(rd_fetch_addr_s)];
        end
    end

`ifdef AXI_RAM_READ_PIPE_EN
    logic                  out_valid_r, out_last_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [ID_WIDTH-1:0]   out_id_r;

    // Output stage refills whenever it is empty or being drained this cycle.
    assign core_ready_s    = !out_valid_r || s_axi_rready;
    assign rd_drain_busy_s = out_valid_r && !s_axi_rready;

    // R channel output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
            out_id_r    <= '0;
        end else if (core_ready_s) begin
            out_valid_r <= core_valid_r;
            out_last_r  <= core_last_r;
            out_data_r  <= core_data_r;
            out_id_r    <= rd_id_r;
        end
    end

    assign s_axi_rvalid = out_valid_r;
    assign s_axi_rlast  = out_last_r;
    assign s_axi_rdata  = out_data_r;
    assign s_axi_rid    = out_id_r;
`else
    assign core_ready_s    = s_axi_rready;
    assign rd_drain_busy_s = 1'b0;
    assign s_axi_rvalid    = core_valid_r;
    assign s_axi_rlast     = core_last_r;
    assign s_axi_rdata     = core_data_r;
    assign s_axi_rid       = rd_id_r;
`endif

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bid     = wr_id_r;
    assign s_axi_bresp   = RESP_OKAY;
    assign s_axi_arready = arready_r;
    assign s_axi_rresp   = RESP_OKAY;

    logic unused_s;
    assign unused_s = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_wlast,
                        s_axi_arlock, s_axi_arcache, s_axi_arprot};

endmodule

// File: tb/tb_axi4_ram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi4_ram_slave
//   Self-checking bench for axi4_ram_slave (32-bit data, 12-bit address).
//   A byte-array model holds expected RAM contents; beat addresses are
//   computed in closed form from the burst rules. Only bytes the model has
//   written are compared on reads.
// -----------------------------------------------------------------------------
module tb_axi4_ram_slave;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int SW = 4;
    localparam int IW = 8;
`ifdef AXI_RAM_READ_PIPE_EN
    localparam int RD_LAT = 1;
`else
    localparam int RD_LAT = 0;
`endif

    logic          clk, rst;
    logic [IW-1:0] s_axi_awid;
    logic [AW-1:0] s_axi_awaddr;
    logic [7:0]    s_axi_awlen;
    logic [2:0]    s_axi_awsize;
    logic [1:0]    s_axi_awburst;
    logic          s_axi_awlock;
    logic [3:0]    s_axi_awcache;
    logic [2:0]    s_axi_awprot;
    logic          s_axi_awvalid, s_axi_awready;
    logic [DW-1:0] s_axi_wdata;
    logic [SW-1:0] s_axi_wstrb;
    logic          s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [IW-1:0] s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid, s_axi_bready;
    logic [IW-1:0] s_axi_arid;
    logic [AW-1:0] s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic [2:0]    s_axi_arsize;
    logic [1:0]    s_axi_arburst;
    logic          s_axi_arlock;
    logic [3:0]    s_axi_arcache;
    logic [2:0]    s_axi_arprot;
    logic          s_axi_arvalid, s_axi_arready;
    logic [IW-1:0] s_axi_rid;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;

    axi4_ram_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference memory: bytes plus a "has been written" flag.
    logic [7:0] model_mem   [0:4095];
    bit         model_known [0:4095];

    // Write stimulus and captured results.
    logic [31:0] wdata_q [0:255];
    logic [3:0]  wstrb_q [0:255];
    logic [7:0]  got_bid;
    logic [1:0]  got_bresp;
    int          b_count;
    bit          b_unstable, wr_timeout;

    logic [31:0] got_data [0:255];
    logic        got_last [0:255];
    logic [7:0]  got_rid  [0:255];
    logic [1:0]  got_resp [0:255];
    int          rd_beats, rd_cycles, first_wait, hold_err;
    bit          rd_timeout;
    logic        rd_after_valid;

    // Byte address of beat i: FIXED stays put, INCR/WRAP step by 2**size, mod 4096.
    function automatic logic [11:0] beat_addr(input logic [11:0] start, input logic [2:0] size,
                                              input logic [1:0] burst, input int i);
        int step;
        step = (burst == 2'b00) ? 0 : (1 << size);
        return 12'(int'(start) + i * step);
    endfunction

    function automatic logic [31:0] model_word(input logic [11:0] a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[b*8 +: 8] = model_mem[{a[11:2], 2'(b)}];
        return w;
    endfunction

    function automatic logic [31:0] model_mask(input logic [11:0] a);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = model_known[{a[11:2], 2'(b)}] ? 8'hff : 8'h00;
        return m;
    endfunction

    task automatic axi_write(input logic [7:0] id, input logic [11:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        int n;
        logic [11:0] a;
        wr_timeout = 1'b0;
        b_unstable = 1'b0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        n = 0;
        while (s_axi_awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) wr_timeout = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_wvalid = 1'b0;
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            s_axi_wdata = wdata_q[i]; s_axi_wstrb = wstrb_q[i];
            s_axi_wlast = (i == int'(len)); s_axi_wvalid = 1'b1;
            n = 0;
            while (s_axi_wready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
            if (n >= 50) wr_timeout = 1'b1;
            @(posedge clk); #1;
            a = beat_addr(addr, size, burst, i);
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[i][b]) begin
                    model_mem[{a[11:2], 2'(b)}]   = wdata_q[i][b*8 +: 8];
                    model_known[{a[11:2], 2'(b)}] = 1'b1;
                end
            end
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        n = 0;
        while (s_axi_bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) wr_timeout = 1'b1;
        got_bid = s_axi_bid; got_bresp = s_axi_bresp;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            if (s_axi_bvalid !== 1'b1 || s_axi_bid !== got_bid) b_unstable = 1'b1;
        end
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        b_count = 1;
        repeat (3) begin
            if (s_axi_bvalid === 1'b1) b_count++;
            @(posedge clk); #1;
        end
    endtask

    task automatic axi_read(input logic [7:0] id, input logic [11:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int stall_beat, input int stall_cycles);
        int n, k, stall_left;
        bit hs, held_set;
        logic [31:0] held_data;
        logic held_last;
        rd_timeout = 1'b0; hold_err = 0; first_wait = -1; held_set = 1'b0;
        held_data = 32'h0; held_last = 1'b0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        n = 0;
        while (s_axi_arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) rd_timeout = 1'b1;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        k = 0; n = 0; stall_left = stall_cycles;
        while (k <= int'(len) && n < 400) begin
            hs = 1'b0;
            if (s_axi_rvalid === 1'b1) begin
                if (first_wait < 0) first_wait = n;
                if (k == stall_beat && stall_left > 0) begin
                    s_axi_rready = 1'b0;
                    if (!held_set) begin
                        held_data = s_axi_rdata; held_last = s_axi_rlast; held_set = 1'b1;
                    end else if (s_axi_rdata !== held_data || s_axi_rlast !== held_last) begin
                        hold_err++;
                    end
                    stall_left--;
                end else begin
                    s_axi_rready = 1'b1;
                    if (held_set && k == stall_beat &&
                        (s_axi_rdata !== held_data || s_axi_rlast !== held_last)) hold_err++;
                    got_data[k] = s_axi_rdata; got_last[k] = s_axi_rlast;
                    got_rid[k] = s_axi_rid; got_resp[k] = s_axi_rresp;
                    hs = 1'b1;
                end
            end else begin
                s_axi_rready = 1'b0;
            end
            @(posedge clk); #1; n++;
            if (hs) k++;
        end
        s_axi_rready = 1'b0;
        rd_beats = k; rd_cycles = n;
        if (k <= int'(len)) rd_timeout = 1'b1;
        rd_after_valid = s_axi_rvalid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
             s_axi_bresp, s_axi_rresp} !== 10'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0", {s_axi_awready, s_axi_wready, s_axi_bvalid,
                     s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_bresp, s_axi_rresp});
        end
        checks++;
        if ({s_axi_bid, s_axi_rid} !== 16'h0) begin
            failures++; $display("FAIL reset_ids got=%h want=0000", {s_axi_bid, s_axi_rid});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({s_axi_awready, s_axi_arready, s_axi_wready} !== 3'b110) begin
            failures++;
            $display("FAIL idle_ready got=%b want=110", {s_axi_awready, s_axi_arready, s_axi_wready});
        end
    endtask

    task automatic test_incr_write();
        wdata_q[0] = 32'hdeadbeef; wdata_q[1] = 32'hc0decafe; wdata_q[2] = 32'hbabeb00b;
        for (int i = 0; i < 3; i++) wstrb_q[i] = 4'hf;
        axi_write(8'hA5, 12'h100, 8'd2, 3'd2, 2'b01);
        checks++;
        if (wr_timeout !== 1'b0) begin failures++; $display("FAIL incr_wr_timeout got=1 want=0"); end
        checks++;
        if (got_bresp !== 2'b00) begin failures++; $display("FAIL incr_bresp got=%b want=00", got_bresp); end
        checks++;
        if (got_bid !== 8'hA5) begin failures++; $display("FAIL incr_bid got=%h want=a5", got_bid); end
        checks++;
        if (b_count !== 1 || b_unstable !== 1'b0) begin
            failures++; $display("FAIL incr_bcount got=%0d unstable=%0d want=1/0", b_count, b_unstable);
        end
    endtask

    task automatic test_incr_read();
        logic [31:0] exp [0:2];
        exp[0] = 32'hdeadbeef; exp[1] = 32'hc0decafe; exp[2] = 32'hbabeb00b;
        axi_read(8'h3C, 12'h100, 8'd2, 3'd2, 2'b01, -1, 0);
        checks++;
        if (rd_timeout !== 1'b0) begin failures++; $display("FAIL incr_rd_timeout beats=%0d want=3", rd_beats); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_data[i] !== exp[i] || got_last[i] !== (i == 2) || got_resp[i] !== 2'b00 ||
                got_rid[i] !== 8'h3C) begin
                failures++;
                $display("FAIL incr_rd_beat%0d got=%h/%b/%b/%h want=%h/%b/00/3c", i, got_data[i],
                         got_last[i], got_resp[i], got_rid[i], exp[i], (i == 2));
            end
        end
        checks++;
        if (first_wait !== RD_LAT) begin failures++; $display("FAIL rd_latency got=%0d want=%0d", first_wait, RD_LAT); end
        checks++;
        if (rd_cycles !== 3 + RD_LAT || rd_after_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_throughput got=%0d/%b want=%0d/0", rd_cycles, rd_after_valid, 3 + RD_LAT);
        end
    endtask

    task automatic test_strobe();
        wdata_q[0] = 32'hffffffff; wstrb_q[0] = 4'hf;
        axi_write(8'h01, 12'h200, 8'd0, 3'd2, 2'b01);
        wdata_q[0] = 32'h11223344; wstrb_q[0] = 4'b0101;
        axi_write(8'h02, 12'h200, 8'd0, 3'd2, 2'b01);
        checks++;
        if (got_bid !== 8'h02 || b_count !== 1) begin
            failures++; $display("FAIL strb_b got=%h/%0d want=02/1", got_bid, b_count);
        end
        axi_read(8'h03, 12'h200, 8'd0, 3'd2, 2'b01, -1, 0);
        checks++;
        if (got_data[0] !== 32'hff22ff44 || got_last[0] !== 1'b1) begin
            failures++; $display("FAIL strb_data got=%h/%b want=ff22ff44/1", got_data[0], got_last[0]);
        end
    endtask

    task automatic test_fixed();
        for (int i = 0; i < 4; i++) begin wdata_q[i] = 32'(i + 1); wstrb_q[i] = 4'hf; end
        axi_write(8'h10, 12'h300, 8'd3, 3'd2, 2'b00);
        axi_read(8'h11, 12'h300, 8'd0, 3'd2, 2'b01, -1, 0);
        checks++;
        if (got_data[0] !== 32'h4) begin failures++; $display("FAIL fixed_data got=%h want=00000004", got_data[0]); end
    endtask

    task automatic test_addr_wrap();
        wdata_q[0] = 32'haaaa0001; wdata_q[1] = 32'hbbbb0002; wstrb_q[0] = 4'hf; wstrb_q[1] = 4'hf;
        axi_write(8'h20, 12'hffc, 8'd1, 3'd2, 2'b01);
        axi_read(8'h21, 12'h000, 8'd0, 3'd2, 2'b01, -1, 0);
        checks++;
        if (got_data[0] !== 32'hbbbb0002) begin failures++; $display("FAIL wrap_low got=%h want=bbbb0002", got_data[0]); end
        axi_read(8'h22, 12'hffc, 8'd1, 3'd2, 2'b10, -1, 0);
        checks++;
        if (got_data[0] !== 32'haaaa0001 || got_data[1] !== 32'hbbbb0002) begin
            failures++;
            $display("FAIL wrap_burst got=%h,%h want=aaaa0001,bbbb0002", got_data[0], got_data[1]);
        end
    endtask

    task automatic test_rready_stall();
        logic [11:0] a;
        for (int i = 0; i < 4; i++) begin wdata_q[i] = $urandom; wstrb_q[i] = 4'hf; end
        axi_write(8'h30, 12'h500, 8'd3, 3'd2, 2'b01);
        axi_read(8'h31, 12'h500, 8'd3, 3'd2, 2'b01, 1, 5);
        checks++;
        if (hold_err !== 0 || rd_beats !== 4) begin
            failures++; $display("FAIL stall_hold got=%0d/%0d want=0/4", hold_err, rd_beats);
        end
        checks++;
        if (rd_cycles !== 4 + 5 + RD_LAT) begin
            failures++; $display("FAIL stall_cycles got=%0d want=%0d", rd_cycles, 9 + RD_LAT);
        end
        for (int i = 0; i < 4; i++) begin
            a = beat_addr(12'h500, 3'd2, 2'b01, i);
            checks++;
            if (got_data[i] !== model_word(a) || got_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL stall_beat%0d got=%h/%b want=%h/%b", i, got_data[i], got_last[i],
                         model_word(a), (i == 3));
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n, seen;
        s_axi_awid = 8'h5A; s_axi_awaddr = 12'h400; s_axi_awlen = 8'd3;
        s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
        n = 0;
        while (s_axi_awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hf; s_axi_wvalid = 1'b1;
        n = 0;
        while (s_axi_wready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0;
        checks++;
        if (s_axi_wready !== 1'b1) begin failures++; $display("FAIL midburst_wready got=%b want=1", s_axi_wready); end
        rst = 1'b1;
        #1;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
             s_axi_bid, s_axi_rid} !== 22'h0) begin
            failures++;
            $display("FAIL midburst_reset got=%b/%h/%h want=0", {s_axi_awready, s_axi_wready,
                     s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast}, s_axi_bid, s_axi_rid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (4) begin @(posedge clk); #1; if (s_axi_bvalid === 1'b1) seen++; end
        checks++;
        if (seen !== 0 || s_axi_awready !== 1'b1) begin
            failures++; $display("FAIL midburst_nob got=%0d/%b want=0/1", seen, s_axi_awready);
        end
        wdata_q[0] = 32'h0badf00d; wdata_q[1] = 32'h600dcafe; wstrb_q[0] = 4'hf; wstrb_q[1] = 4'hf;
        axi_write(8'h6B, 12'h480, 8'd1, 3'd2, 2'b01);
        checks++;
        if (wr_timeout !== 1'b0 || got_bid !== 8'h6B || b_count !== 1) begin
            failures++; $display("FAIL post_reset_wr got=%b/%h/%0d want=0/6b/1", wr_timeout, got_bid, b_count);
        end
        axi_read(8'h6C, 12'h480, 8'd1, 3'd2, 2'b01, -1, 0);
        checks++;
        if (got_data[0] !== 32'h0badf00d || got_data[1] !== 32'h600dcafe) begin
            failures++;
            $display("FAIL post_reset_rd got=%h,%h want=0badf00d,600dcafe", got_data[0], got_data[1]);
        end
    endtask

    task automatic test_random();
        logic [7:0] id, len;
        logic [11:0] addr, a;
        logic [2:0] size;
        logic [1:0] burst;
        logic [31:0] m;
        for (int t = 0; t < 16; t++) begin
            id = 8'($urandom); addr = 12'($urandom); len = 8'($urandom_range(0, 7));
            size = 3'($urandom_range(0, 2)); burst = 2'($urandom_range(0, 2));
            for (int i = 0; i <= int'(len); i++) begin
                wdata_q[i] = $urandom; wstrb_q[i] = 4'($urandom_range(0, 15));
            end
            axi_write(id, addr, len, size, burst);
            checks++;
            if (wr_timeout !== 1'b0 || got_bid !== id || got_bresp !== 2'b00 || b_count !== 1 ||
                b_unstable !== 1'b0) begin
                failures++;
                $display("FAIL rand_b%0d got=%b/%h/%b/%0d want=0/%h/00/1", t, wr_timeout, got_bid,
                         got_bresp, b_count, id);
            end
            axi_read(~id, addr, len, size, burst, -1, 0);
            checks++;
            if (rd_timeout !== 1'b0 || rd_cycles !== int'(len) + 1 + RD_LAT) begin
                failures++;
                $display("FAIL rand_rd%0d got=%b/%0d want=0/%0d", t, rd_timeout, rd_cycles,
                         int'(len) + 1 + RD_LAT);
            end
            for (int i = 0; i <= int'(len); i++) begin
                a = beat_addr(addr, size, burst, i);
                m = model_mask(a);
                checks++;
                if ((got_data[i] & m) !== (model_word(a) & m) || got_last[i] !== (i == int'(len)) ||
                    got_rid[i] !== ~id || got_resp[i] !== 2'b00) begin
                    failures++;
                    $display("FAIL rand_data%0d_%0d got=%h/%b/%h want=%h/%b/%h mask=%h", t, i,
                             got_data[i], got_last[i], got_rid[i], model_word(a),
                             (i == int'(len)), ~id, m);
                end
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < 4096; i++) begin model_known[i] = 1'b0; model_mem[i] = 8'h00; end
        rst = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = 8'd0; s_axi_awsize = 3'd0;
        s_axi_awburst = 2'b00; s_axi_awlock = 1'b0; s_axi_awcache = 4'd0; s_axi_awprot = 3'd0;
        s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = 8'd0; s_axi_arsize = 3'd0;
        s_axi_arburst = 2'b00; s_axi_arlock = 1'b0; s_axi_arcache = 4'd0; s_axi_arprot = 3'd0;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        test_reset();
        test_incr_write();
        test_incr_read();
        test_strobe();
        test_fixed();
        test_addr_wrap();
        test_rready_stall();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
